// File: rtl/vr_pkg.sv
// Shared types and helpers for the valid/ready arbiter fabric.
// Used by vr_rr_pick and vr_rr_arbiter.
package vr_pkg;

    typedef enum logic {
        ST_IDLE,
        ST_LOCKED
    } state_e;

    localparam int DEF_WIDTH = 32;

    // ceil(log2(v)), never less than 1 so a 1-bit index is always legal
    function automatic int clog2(input int v);
        int r;
        r = 1;
        while ((1 << r) < v) begin
            r = r + 1;
        end
        return r;
    endfunction

endpackage

// File: rtl/vr_rr_pick.sv
// Rotate-priority selector: first set request at or after ptr, modulo N.
// Purely combinational; ptr must already be in 0..N-1.
module vr_rr_pick
    import vr_pkg::*;
#(
    parameter int N    = 4,
    parameter int ID_W = clog2(N)
) (
    input  logic [N-1:0]    req,
    input  logic [ID_W-1:0] ptr,
    output logic            any,
    output logic [ID_W-1:0] sel
);

    int idx;

    always_comb begin
        any = 1'b0;
        sel = '0;
        idx = 0;
        for (int i = 0; i < N; i++) begin
            // one conditional subtract keeps idx in 0..N-1 for any N
            idx = int'(ptr) + i;
            if (idx >= N) begin
                idx = idx - N;
            end
            if (!any && req[idx]) begin
                any = 1'b1;
                sel = ID_W'(idx);
            end
        end
    end

endmodule

// File: rtl/vr_rr_arbiter.sv
// N-to-1 packet-locked round-robin arbiter with a registered output stage.
// A grant is held from the first beat until the accepted last beat.
module vr_rr_arbiter
    import vr_pkg::*;
#(
    parameter int WIDTH = DEF_WIDTH,
    parameter int N     = 4,
    parameter int ID_W  = clog2(N)
) (
    input  logic             clk,
    input  logic             rstn,
    input  logic [N-1:0]     s_valid,
    output logic [N-1:0]     s_ready,
    input  logic [N*WIDTH-1:0] s_data,
    input  logic [N-1:0]     s_last,
    output logic             m_valid,
    input  logic             m_ready,
    output logic [WIDTH-1:0] m_data,
    output logic             m_last,
    output logic [ID_W-1:0]  m_id
);

    state_e          state_q, state_d;
    logic [ID_W-1:0] ptr_q, ptr_d;
    logic [ID_W-1:0] owner_q, owner_d;

    logic             m_valid_q, m_valid_d;
    logic [WIDTH-1:0] m_data_q, m_data_d;
    logic             m_last_q, m_last_d;
    logic [ID_W-1:0]  m_id_q, m_id_d;

    logic             any;
    logic [ID_W-1:0]  sel;
    logic [ID_W-1:0]  gnt_id;
    logic             gnt_en;
    logic             slot_free;
    logic             accept;
    logic             acc_last;
    logic [WIDTH-1:0] acc_data;

    function automatic logic [ID_W-1:0] next_idx(input logic [ID_W-1:0] i);
        return (int'(i) == N - 1) ? '0 : i + 1'b1;
    endfunction

    vr_rr_pick #(
        .N    (N),
        .ID_W (ID_W)
    ) u_pick (
        .req (s_valid),
        .ptr (ptr_q),
        .any (any),
        .sel (sel)
    );

    // Grant path: depends on m_ready only via slot_free, never on it via s_valid.
    always_comb begin
        slot_free = !m_valid_q || m_ready;
        gnt_id    = (state_q == ST_LOCKED) ? owner_q : sel;
        gnt_en    = rstn && slot_free &&
                    ((state_q == ST_LOCKED) || any);
        s_ready   = '0;
        if (gnt_en) begin
            s_ready[gnt_id] = 1'b1;
        end
        accept   = |(s_valid & s_ready);
        acc_last = s_last[gnt_id];
        acc_data = s_data[int'(gnt_id)*WIDTH +: WIDTH];
    end

    always_comb begin
        state_d = state_q;
        ptr_d   = ptr_q;
        owner_d = owner_q;
        unique case (state_q)
            ST_IDLE: begin
                if (accept) begin
                    if (acc_last) begin
                        ptr_d = next_idx(sel);
                    end else begin
                        state_d = ST_LOCKED;
                        owner_d = sel;
                    end
                end
            end
            ST_LOCKED: begin
                if (accept && acc_last) begin
                    state_d = ST_IDLE;
                    ptr_d   = next_idx(owner_q);
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_comb begin
        m_valid_d = m_valid_q;
        m_data_d  = m_data_q;
        m_last_d  = m_last_q;
        m_id_d    = m_id_q;
        if (accept) begin
            m_valid_d = 1'b1;
            m_data_d  = acc_data;
            m_last_d  = acc_last;
            m_id_d    = gnt_id;
        end else if (m_ready) begin
            m_valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q   <= ST_IDLE;
            ptr_q     <= '0;
            owner_q   <= '0;
            m_valid_q <= 1'b0;
            m_data_q  <= '0;
            m_last_q  <= 1'b0;
            m_id_q    <= '0;
        end else begin
            state_q   <= state_d;
            ptr_q     <= ptr_d;
            owner_q   <= owner_d;
            m_valid_q <= m_valid_d;
            m_data_q  <= m_data_d;
            m_last_q  <= m_last_d;
            m_id_q    <= m_id_d;
        end
    end

    assign m_valid = m_valid_q;
    assign m_data  = m_data_q;
    assign m_last  = m_last_q;
    assign m_id    = m_id_q;

endmodule

// File: doc/vr_rr_arbiter.md
# vr_rr_arbiter

N-to-1 round-robin arbiter that shares one downstream valid/ready channel among N upstream masters. Transfers are packets delimited by a `last` flag; a grant is held from the first beat to the accepted `last` beat, so packets never interleave. The output is fully registered (valid-flop stage), and this block sits between several bus masters and a single slave port in the handshake fabric.

## Interface
- `WIDTH`, 32, data bits per beat
- `N`, 4, number of upstream requesters (2..16)
- `ID_W`, $clog2(N), width of the source-index output
- `clk`  in  1  clock, all logic on rising edge
- `rstn`  in  1  reset, asynchronous, active-low
- `s_valid`  in  N  per-requester valid
- `s_ready`  out  N  per-requester ready, at most one bit set
- `s_data`  in  N*WIDTH  requester i occupies bits [i*WIDTH +: WIDTH]
- `s_last`  in  N  per-requester last-beat flag
- `m_valid`  out  1  registered valid to the slave
- `m_ready`  in  1  ready from the slave
- `m_data`  out  WIDTH  registered data
- `m_last`  out  1  registered last flag
- `m_id`  out  ID_W  index of the requester that produced the current beat

## Operation
- Slot free: `slot_free = !m_valid | m_ready`. A beat is accepted from requester i when `s_valid[i] & s_ready[i]`.
- Round-robin pointer `ptr` (ID_W bits, reset 0). Candidate search starts at `ptr` and proceeds ptr, ptr+1, … N-1, 0, … modulo N. The first requester with `s_valid` set wins.
- **IDLE state:**
  - `sel` is the combinational winner.
  - `s_ready[sel] = slot_free` when any `s_valid` is set; all other ready bits are 0.
  - On an accepted beat with `s_last = 0`: go to LOCKED, `owner <= sel`.
  - On an accepted beat with `s_last = 1`: stay in IDLE, `ptr <= sel + 1` (mod N).
- **LOCKED state:**
  - `s_ready[owner] = slot_free`; all other ready bits are 0, whatever their valid.
  - The owner may deassert `s_valid` between beats. The lock is held and other requesters stay blocked.
  - An accepted beat with `s_last = 1` returns the FSM to IDLE, `ptr <= owner + 1` (mod N).
- **Output register:**
  - On an accepted beat: `m_valid <= 1`, and `m_data`, `m_last`, `m_id` load the accepted beat's data, last and source index.
  - Else if `m_ready`: `m_valid <= 0`. The data, last and id fields hold their values.
- `s_ready` does not depend on any `s_valid` in LOCKED. In IDLE it depends only through the arbitration result, with no combinational path from `m_ready` into `s_valid`.
- Wrap-around: `ptr` at N-1 advances to 0. For non-power-of-two N, index N must never be produced.

## Timing
- Reset values:
  - `m_valid = 0`, `m_data = 0`, `m_last = 0`, `m_id = 0`
  - state IDLE, `ptr = 0`, `owner = 0`
  - `s_ready` = all 0 while `rstn` is low.
- Latency: an input beat accepted at edge k appears on `m_*` immediately after edge k. It is consumed at the first edge ≥ k+1 with `m_ready = 1`.
- Throughput: 1 beat per cycle when `m_ready` is held high, including back-to-back packets from different requesters. There is no idle cycle at a grant change.
- Backpressure: when `m_valid = 1` and `m_ready = 0`, all `s_ready` bits are 0 and `m_*` stays stable.
- Simultaneous events:
  - The output beat drains and a new beat is accepted on the same edge; `m_valid` stays 1 with the new data.
  - A `last` beat is accepted in the same cycle other requesters are valid; the next grant is evaluated from the new `ptr` in the following cycle.
- Reset mid-packet: the lock and any buffered beat are discarded and the FSM restarts in IDLE with `ptr = 0`. Upstream is responsible for packet recovery.

## Structure
- Shared package `vr_pkg`:
  - state enum `{ST_IDLE, ST_LOCKED}`
  - constant function `clog2`
  - default `WIDTH`
- Sub-module `vr_rr_pick`: combinational rotate-priority selector with inputs `req[N]`, `ptr` and outputs `any`, `sel`. It is reusable by later arbiters.
- The top level contains the FSM, `ptr` and `owner` registers, and the output register stage.

## Test plan
- Reset, then `s_valid = 4'b1111`, all `s_last = 1`, `m_ready = 1`. Required: `m_id` sequence is 0,1,2,3,0 on consecutive cycles, one beat per cycle.
- Requester 1 sends a 3-beat packet (0xA1, 0xA2, 0xA3), and requester 2 is valid throughout. Required: `m_id = 1` for 3 beats, then requester 2 is granted. No interleaving occurs.
- Requester 0 is mid-packet and drops `s_valid` for 2 cycles while requester 3 is valid. Required: `s_ready[3]` stays 0 until requester 0's `last` beat is accepted.
- Hold `m_ready = 0` for 5 cycles with `m_valid = 1` and data 0x55. Required: `m_data` stays 0x55, all `s_ready = 0`. After release, the next beat follows with no bubble.
- N = 3: `ptr` wraps from requester 2 to requester 0. Required: `m_id` never equals 3.
- Assert `rstn` low during beat 2 of a 4-beat packet. Required: `m_valid = 0`, `ptr = 0`, state IDLE. The first grant after reset goes to the lowest-index valid requester.
